// File: rtl/prco_mem_arbiter.sv
// prco_mem_arbiter: arbitrates the single-port local memory between instruction fetch (IF) and
// ALU load/store (LS). Each access runs GRANT -> WAIT (MEM_LAT cycles) -> RESP, with the memory
// address held for the whole access. Rotating priority: on a conflict the port not granted last
// wins. Every output is a register.
//
// Ports:
//   i_clk, i_reset                         clock, synchronous active-high reset
//   i_if_req, i_if_addr                    fetch request and PC
//   q_if_gnt, q_if_valid, q_if_data        fetch grant pulse, response pulse, instruction
//   i_ls_req, i_ls_we, i_ls_addr, i_ls_dina  load/store request, direction, address, store data
//   q_ls_gnt, q_ls_valid, q_ls_data        LS grant pulse, response pulse, load data
//   q_mem_we, q_mem_addr, q_mem_dina       memory write enable, address, write data
//   i_mem_douta                            memory read data
//   q_busy                                 high while an access is in GRANT/WAIT/RESP
module prco_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              q_if_gnt,
  output logic              q_if_valid,
  output logic [DATA_W-1:0] q_if_data,
  input  logic              i_ls_req,
  input  logic              i_ls_we,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_dina,
  output logic              q_ls_gnt,
  output logic              q_ls_valid,
  output logic [DATA_W-1:0] q_ls_data,
  output logic              q_mem_we,
  output logic [ADDR_W-1:0] q_mem_addr,
  output logic [DATA_W-1:0] q_mem_dina,
  input  logic [DATA_W-1:0] i_mem_douta,
  output logic              q_busy
);

  localparam logic [3:0] WaitInit = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Winner bookkeeping: sel_ls = current access belongs to LS, last_ls = LS was granted last.
  logic sel_ls_q, sel_ls_d;
  logic we_q, we_d;
  logic last_ls_q, last_ls_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0] ls_data_q, ls_data_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dina_q, mem_dina_d;
  logic              busy_q, busy_d;

  logic arb_pt, any_req, pick_ls, last_wait;

  assign arb_pt    = (state_q == StIdle) || (state_q == StResp);
  assign any_req   = i_if_req | i_ls_req;
  // LS wins when it is alone, or on a conflict when IF was granted last.
  assign pick_ls   = i_ls_req & (~i_if_req | ~last_ls_q);
  assign last_wait = (state_q == StWait) && (cnt_q == 4'd0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StResp: state_d = any_req ? StGrant : StIdle;
      StGrant: begin
        state_d = StWait;
        cnt_d   = WaitInit;
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs and the latched winner.
  always_comb begin
    if_gnt_d   = 1'b0;
    ls_gnt_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_valid_d = 1'b0;
    ls_valid_d = 1'b0;
    if_data_d  = if_data_q;
    ls_data_d  = ls_data_q;
    mem_addr_d = mem_addr_q;
    mem_dina_d = mem_dina_q;
    sel_ls_d   = sel_ls_q;
    we_d       = we_q;
    last_ls_d  = last_ls_q;
    busy_d     = (state_d != StIdle);

    if (arb_pt && any_req) begin
      sel_ls_d  = pick_ls;
      last_ls_d = pick_ls;
      if (pick_ls) begin
        ls_gnt_d   = 1'b1;
        mem_addr_d = i_ls_addr;
        mem_dina_d = i_ls_dina;
        mem_we_d   = i_ls_we;
        we_d       = i_ls_we;
      end else begin
        if_gnt_d   = 1'b1;
        mem_addr_d = i_if_addr;
        we_d       = 1'b0;
      end
    end

    // Read data is captured on the last WAIT cycle so it appears together with valid in RESP.
    if (last_wait) begin
      if (sel_ls_q) begin
        ls_valid_d = 1'b1;
        if (!we_q) ls_data_d = i_mem_douta;
      end else begin
        if_valid_d = 1'b1;
        if_data_d  = i_mem_douta;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      if_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_data_q  <= '0;
      ls_gnt_q   <= 1'b0;
      ls_valid_q <= 1'b0;
      ls_data_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dina_q <= '0;
      busy_q     <= 1'b0;
      sel_ls_q   <= 1'b0;
      we_q       <= 1'b0;
      last_ls_q  <= 1'b1;
    end else begin
      if_gnt_q   <= if_gnt_d;
      if_valid_q <= if_valid_d;
      if_data_q  <= if_data_d;
      ls_gnt_q   <= ls_gnt_d;
      ls_valid_q <= ls_valid_d;
      ls_data_q  <= ls_data_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_dina_q <= mem_dina_d;
      busy_q     <= busy_d;
      sel_ls_q   <= sel_ls_d;
      we_q       <= we_d;
      last_ls_q  <= last_ls_d;
    end
  end

  assign q_if_gnt   = if_gnt_q;
  assign q_if_valid = if_valid_q;
  assign q_if_data  = if_data_q;
  assign q_ls_gnt   = ls_gnt_q;
  assign q_ls_valid = ls_valid_q;
  assign q_ls_data  = ls_data_q;
  assign q_mem_we   = mem_we_q;
  assign q_mem_addr = mem_addr_q;
  assign q_mem_dina = mem_dina_q;
  assign q_busy     = busy_q;

endmodule

// File: tb/tb_prco_mem_arbiter.sv
// Bench for prco_mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) share one stimulus stream.
// A transaction-level model predicts every output each cycle; directed literal checks pin it.
module tb_prco_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fill, if_req, ls_req, ls_we;
  logic [15:0] if_addr, ls_addr, ls_dina;

  logic [1:0]       o_if_gnt, o_if_valid, o_ls_gnt, o_ls_valid, o_we, o_busy;
  logic [1:0][15:0] o_if_data, o_ls_data, o_addr, o_dina, douta;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .q_if_gnt(o_if_gnt[0]), .q_if_valid(o_if_valid[0]), .q_if_data(o_if_data[0]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_dina(ls_dina),
    .q_ls_gnt(o_ls_gnt[0]), .q_ls_valid(o_ls_valid[0]), .q_ls_data(o_ls_data[0]),
    .q_mem_we(o_we[0]), .q_mem_addr(o_addr[0]), .q_mem_dina(o_dina[0]),
    .i_mem_douta(douta[0]), .q_busy(o_busy[0])
  );

  prco_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .q_if_gnt(o_if_gnt[1]), .q_if_valid(o_if_valid[1]), .q_if_data(o_if_data[1]),
    .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_dina(ls_dina),
    .q_ls_gnt(o_ls_gnt[1]), .q_ls_valid(o_ls_valid[1]), .q_ls_data(o_ls_data[1]),
    .q_mem_we(o_we[1]), .q_mem_addr(o_addr[1]), .q_mem_dina(o_dina[1]),
    .i_mem_douta(douta[1]), .q_busy(o_busy[1])
  );

  function automatic logic [15:0] init_val(input int a);
    if (a == 4) return 16'hA5C3;
    return 16'(a * 257) ^ 16'h3C00;
  endfunction

  // Memories seen by the DUTs: read pipelines of depth MEM_LAT.
  logic [15:0] dmem0 [1024];
  logic [15:0] dmem1 [1024];
  logic [15:0] pipe0;
  logic [15:0] pipe1 [3];

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) dmem0[i] <= init_val(i);
    else if (o_we[0]) dmem0[o_addr[0][9:0]] <= o_dina[0];
    pipe0 <= dmem0[o_addr[0][9:0]];
  end

  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) dmem1[i] <= init_val(i);
    else if (o_we[1]) dmem1[o_addr[1][9:0]] <= o_dina[1];
    pipe1[0] <= dmem1[o_addr[1][9:0]];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end

  assign douta[0] = pipe0;
  assign douta[1] = pipe1[2];

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h", name, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: expected outputs for the cycle following each rising edge.
  logic        e_if_gnt [2], e_ls_gnt [2], e_if_valid [2], e_ls_valid [2], e_we [2], e_busy [2];
  logic [15:0] e_if_data [2], e_ls_data [2], e_addr [2], e_dina [2];
  int          next_arb [2], busy_until [2], valid_at [2];
  logic        last_ls [2], vport_ls [2], vstore [2];
  logic [15:0] vdata [2];
  logic [15:0] refmem [2][1024];

  initial begin : model
    int n;
    int lat;
    logic win_ls;
    logic [15:0] a;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      e_if_gnt[k] = 0; e_ls_gnt[k] = 0; e_if_valid[k] = 0; e_ls_valid[k] = 0;
      e_we[k] = 0; e_busy[k] = 0; e_if_data[k] = 0; e_ls_data[k] = 0;
      e_addr[k] = 0; e_dina[k] = 0; next_arb[k] = 0; busy_until[k] = -1; valid_at[k] = -1;
      last_ls[k] = 1; vport_ls[k] = 0; vstore[k] = 0; vdata[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? 1 : 3;
        if (fill) for (int i = 0; i < 1024; i++) refmem[k][i] = init_val(i);
        if (rst) begin
          e_if_gnt[k] = 0; e_ls_gnt[k] = 0; e_if_valid[k] = 0; e_ls_valid[k] = 0;
          e_we[k] = 0; e_busy[k] = 0; e_if_data[k] = 0; e_ls_data[k] = 0;
          e_addr[k] = 0; e_dina[k] = 0;
          next_arb[k] = n + 1; busy_until[k] = -1; valid_at[k] = -1; last_ls[k] = 1;
        end else begin
          e_if_gnt[k] = 0; e_ls_gnt[k] = 0; e_we[k] = 0;
          e_if_valid[k] = 0; e_ls_valid[k] = 0;
          if (valid_at[k] == n + 1) begin
            if (vport_ls[k]) begin
              e_ls_valid[k] = 1;
              if (!vstore[k]) e_ls_data[k] = vdata[k];
            end else begin
              e_if_valid[k] = 1;
              e_if_data[k]  = vdata[k];
            end
          end
          if (n >= next_arb[k] && (if_req || ls_req)) begin
            if (if_req && ls_req) win_ls = !last_ls[k];
            else                  win_ls = ls_req;
            last_ls[k]  = win_ls;
            vport_ls[k] = win_ls;
            if (win_ls) begin
              a = ls_addr;
              e_ls_gnt[k] = 1;
              e_we[k]     = ls_we;
              e_dina[k]   = ls_dina;
              vstore[k]   = ls_we;
            end else begin
              a = if_addr;
              e_if_gnt[k] = 1;
              vstore[k]   = 0;
            end
            e_addr[k] = a;
            if (vstore[k]) refmem[k][a[9:0]] = ls_dina;
            else           vdata[k] = refmem[k][a[9:0]];
            valid_at[k]   = n + lat + 2;
            next_arb[k]   = n + lat + 2;
            busy_until[k] = n + lat + 2;
          end
          e_busy[k] = (n + 1 <= busy_until[k]);
        end
      end
      n++;
    end
  end

  // Per-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          chk("if_gnt", k, 32'(o_if_gnt[k]), 32'(e_if_gnt[k]));
          chk("if_valid", k, 32'(o_if_valid[k]), 32'(e_if_valid[k]));
          chk("if_data", k, 32'(o_if_data[k]), 32'(e_if_data[k]));
          chk("ls_gnt", k, 32'(o_ls_gnt[k]), 32'(e_ls_gnt[k]));
          chk("ls_valid", k, 32'(o_ls_valid[k]), 32'(e_ls_valid[k]));
          chk("ls_data", k, 32'(o_ls_data[k]), 32'(e_ls_data[k]));
          chk("mem_we", k, 32'(o_we[k]), 32'(e_we[k]));
          chk("mem_addr", k, 32'(o_addr[k]), 32'(e_addr[k]));
          chk("mem_dina", k, 32'(o_dina[k]), 32'(e_dina[k]));
          chk("busy", k, 32'(o_busy[k]), 32'(e_busy[k]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    rst = 1; fill = 1; if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = 0; ls_addr = 0; ls_dina = 0;
    step(3);
    chk_en = 1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", k, 32'(o_busy[k]), 32'd0);
      chk("rst_addr", k, 32'(o_addr[k]), 32'd0);
      chk("rst_ls_data", k, 32'(o_ls_data[k]), 32'd0);
    end
    rst = 0; fill = 0;
    step(1);

    // Fetch from 0x0004 (latency 1 and 3); LS pulse during WAIT must be ignored.
    if_req = 1; if_addr = 16'h0004;
    step(1);
    chk("t1_if_gnt", 0, 32'(o_if_gnt[0]), 32'd1);
    chk("t1_addr", 0, 32'(o_addr[0]), 32'h0004);
    chk("t1_if_gnt", 1, 32'(o_if_gnt[1]), 32'd1);
    if_req = 0;
    step(1);
    chk("t2_addr", 0, 32'(o_addr[0]), 32'h0004);
    ls_req = 1; ls_addr = 16'h0030; ls_we = 0;
    step(1);
    ls_req = 0;
    chk("t3_if_valid", 0, 32'(o_if_valid[0]), 32'd1);
    chk("t3_if_data", 0, 32'(o_if_data[0]), 32'hA5C3);
    chk("t3_ls_gnt", 0, 32'(o_ls_gnt[0]), 32'd0);
    chk("t3_addr", 1, 32'(o_addr[1]), 32'h0004);
    step(1);
    chk("t4_addr", 1, 32'(o_addr[1]), 32'h0004);
    chk("t4_if_valid", 1, 32'(o_if_valid[1]), 32'd0);
    step(1);
    chk("t5_if_valid", 1, 32'(o_if_valid[1]), 32'd1);
    chk("t5_if_data", 1, 32'(o_if_data[1]), 32'hA5C3);
    chk("t5_ls_valid", 0, 32'(o_ls_valid[0]), 32'd0);
    step(2);

    // Store 0x1234 to 0x0100, then load it back.
    ls_req = 1; ls_we = 1; ls_addr = 16'h0100; ls_dina = 16'h1234;
    step(1);
    chk("st_gnt", 0, 32'(o_ls_gnt[0]), 32'd1);
    chk("st_we", 0, 32'(o_we[0]), 32'd1);
    chk("st_dina", 0, 32'(o_dina[0]), 32'h1234);
    ls_req = 0; ls_we = 0;
    step(1);
    chk("st_we_wait", 0, 32'(o_we[0]), 32'd0);
    step(1);
    chk("st_valid", 0, 32'(o_ls_valid[0]), 32'd1);
    chk("st_ls_data", 0, 32'(o_ls_data[0]), 32'd0);
    step(3);
    ls_req = 1; ls_we = 0; ls_addr = 16'h0100;
    step(1);
    ls_req = 0;
    step(2);
    chk("ld_valid", 0, 32'(o_ls_valid[0]), 32'd1);
    chk("ld_data", 0, 32'(o_ls_data[0]), 32'h1234);
    step(2);
    chk("ld_data", 1, 32'(o_ls_data[1]), 32'h1234);
    step(2);

    // Both requesters held after reset: grants alternate, starting with IF.
    rst = 1;
    step(1);
    rst = 0; if_req = 1; ls_req = 1; if_addr = 16'h0010; ls_addr = 16'h0020; ls_we = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk("alt_if_gnt", 0, 32'(o_if_gnt[0]), 32'(i % 6 == 1));
      chk("alt_ls_gnt", 0, 32'(o_ls_gnt[0]), 32'(i % 6 == 4));
      chk("alt_busy", 0, 32'(o_busy[0]), 32'd1);
      chk("alt_if_gnt", 1, 32'(o_if_gnt[1]), 32'(i % 10 == 1));
      chk("alt_ls_gnt", 1, 32'(o_ls_gnt[1]), 32'(i % 10 == 6));
    end
    if_req = 0; ls_req = 0;
    step(8);

    // Reset during WAIT of a load drops it; IF then wins the first conflict.
    ls_req = 1; ls_we = 0; ls_addr = 16'h0020;
    step(1);
    ls_req = 0;
    step(1);
    rst = 1;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("rw_ls_valid", k, 32'(o_ls_valid[k]), 32'd0);
      chk("rw_busy", k, 32'(o_busy[k]), 32'd0);
      chk("rw_addr", k, 32'(o_addr[k]), 32'd0);
      chk("rw_ls_data", k, 32'(o_ls_data[k]), 32'd0);
    end
    rst = 0; if_req = 1; ls_req = 1; if_addr = 16'h0040; ls_addr = 16'h0050;
    step(1);
    for (int k = 0; k < 2; k++) begin
      chk("rw_if_first", k, 32'(o_if_gnt[k]), 32'd1);
      chk("rw_ls_not", k, 32'(o_ls_gnt[k]), 32'd0);
    end
    if_req = 0; ls_req = 0;
    step(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
